uart_rx_os: RTL
===============

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_MAX, default 9, SHALL set the maximum data bits per frame and the width of data.
REQ-002 Parameter OVERSAMPLE, default 16, SHALL set the number of baud_tick pulses per bit period; it SHALL be an even value of at least 4.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the receive FIFO depth; it SHALL be a power of 2 of at least 2.
REQ-004 clk  input  1  SHALL be the single clock for all logic.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 baud_tick  input  1  SHALL be a one-clk pulse at OVERSAMPLE x the baud rate.
REQ-007 rx  input  1  SHALL be the asynchronous serial line, which idles high.
REQ-008 amountBits  input  4  SHALL select the data bits per frame, valid range 5..DATA_MAX.
REQ-009 parity  input  1  SHALL enable a parity bit when 1.
REQ-010 even  input  1  SHALL select even parity when 1 and odd parity when 0.
REQ-011 stop  input  1  SHALL select 1 stop bit when 0 and 2 stop bits when 1.
REQ-012 data  output  DATA_MAX  SHALL carry the head-of-queue word, LSB-first assembled, with unused MSBs zero.
REQ-013 valid  output  1  SHALL indicate that data holds an unread word.
REQ-014 ack  input  1  SHALL pop the head word when it is high together with valid in the same clk.
REQ-015 parity_err, frame_err  output  1 each  SHALL be per-word flags that travel with data.
REQ-016 overrun  output  1  SHALL be a sticky flag, set when a word is dropped because storage is full.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PAR, STOP. Sample-tick counter sc SHALL be $clog2(OVERSAMPLE) bits wide; it SHALL advance only on baud_tick and wrap at OVERSAMPLE-1.
REQ-019 IDLE -> START SHALL occur on a synchronized rx falling to 0; sc SHALL be cleared on entry.
REQ-020 START: at sc==OVERSAMPLE/2-1, if rx==1 the FSM SHALL return to IDLE (glitch rejection) with no word produced; otherwise it SHALL clear sc and go to DATA.
REQ-021 DATA/PAR/STOP SHALL sample rx at sc==OVERSAMPLE-1 (mid-bit).
REQ-022 DATA SHALL shift bits into position bit_cnt; after amountBits samples it SHALL go to PAR if parity==1, otherwise to STOP.
REQ-023 PAR SHALL set parity_err when the received bit != (^data XOR ~even), evaluated over amountBits bits.
REQ-024 STOP SHALL sample 1+stop bits; any 0 sample SHALL set frame_err. After the last stop sample, the word and its flags SHALL be pushed and the FSM SHALL go to IDLE in the same clk.
REQ-025 A word SHALL be pushed even when it carries an error; the error flags SHALL be stored with that word.
REQ-026 Latency: valid SHALL rise 1 clk after the push clk when storage is empty.
REQ-027 A push while full SHALL drop the new word and set overrun; overrun SHALL be cleared only by rst.
REQ-028 A simultaneous push and pop while full SHALL succeed, with no overrun.
REQ-029 An amountBits value outside 5..DATA_MAX SHALL be clamped to DATA_MAX at frame start.
REQ-030 Configuration inputs SHALL be latched in START and SHALL be ignored for the rest of the frame.
REQ-031 The FIFO read and write pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide and SHALL wrap naturally.

Reset
REQ-032 rst SHALL force: state IDLE, all counters 0, pointers 0, data 0, valid 0, parity_err 0, frame_err 0, overrun 0, and the synchronizer flops to 1.
REQ-033 rst asserted mid-frame SHALL discard the partial frame and all stored words.

Configuration
REQ-034 When UART_RX_FIFO_EN is defined, storage SHALL be a FIFO_DEPTH-entry FIFO and "full" SHALL mean FIFO_DEPTH words are held.
REQ-035 When UART_RX_FIFO_EN is undefined, storage SHALL be a single holding register and "full" SHALL mean valid==1; FIFO_DEPTH SHALL be ignored.

Verification
REQ-036 8N1 frame 0xA5, ack held high -> data=0x0A5, valid for 1 clk, both error flags 0.
REQ-037 7E2 frame 0x41 with a wrong parity bit -> data=0x041, parity_err=1, frame_err=0.
REQ-038 9-bit frame 0x1FF, second stop bit driven 0 -> data=0x1FF, frame_err=1.
REQ-039 A 0 pulse on rx lasting OVERSAMPLE/4 ticks -> no word produced, FSM back in IDLE.
REQ-040 With FIFO enabled, 9 frames 0x01..0x09 and ack=0 -> 8 words read back in order 0x01..0x08, then overrun=1; with FIFO disabled, 2 frames -> data=0x01, overrun=1.
REQ-041 rst pulsed during the DATA state of frame 0x55, followed by a full frame 0x33 -> exactly one word, 0x33.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, glitch-rejecting start detect, per-word error flags.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO; otherwise a single holding register.
module uart_rx_os #(
    parameter int DATA_MAX   = 9,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_tick,
    input  logic                rx,
    input  logic [3:0]          amountBits,
    input  logic                parity,
    input  logic                even,
    input  logic                stop,
    output logic [DATA_MAX-1:0] data,
    output logic                valid,
    input  logic                ack,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int WORD_W = DATA_MAX + 2;
    localparam logic [SC_W-1:0] SC_MID = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [3:0] BITS_MAX = 4'(DATA_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Bit the sender must place in the parity slot for the given data and parity sense.
    function automatic logic expected_parity(input logic [DATA_MAX-1:0] bits, input logic even_sel);
        return (^bits) ^ ~even_sel;
    endfunction

    logic rx_meta_r, rx_sync_r, rx_prev_r;
    logic rx_fall_s, sample_s;
    state_t state_r, state_nxt_s;
    logic [SC_W-1:0] sc_r, sc_nxt_s;
    logic [3:0] bit_cnt_r, bit_cnt_nxt_s;
    logic stop_cnt_r, stop_cnt_nxt_s;
    logic [DATA_MAX-1:0] shift_r, shift_nxt_s;
    logic perr_r, perr_nxt_s, ferr_r, ferr_nxt_s;
    logic [3:0] nbits_r, nbits_nxt_s, nbits_in_s;
    logic par_en_r, par_en_nxt_s, even_r, even_nxt_s, stop2_r, stop2_nxt_s;
    logic push_s;
    logic [WORD_W-1:0] push_word_s;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;
    assign sample_s = baud_tick & (sc_r == SC_LAST);
    assign nbits_in_s = ((amountBits < 4'd5) || (amountBits > BITS_MAX)) ? BITS_MAX : amountBits;

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            sc_r       <= SC_W'(0);
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= {DATA_MAX{1'b0}};
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            nbits_r    <= 4'd0;
            par_en_r   <= 1'b0;
            even_r     <= 1'b0;
            stop2_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sc_r       <= sc_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            stop_cnt_r <= stop_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            perr_r     <= perr_nxt_s;
            ferr_r     <= ferr_nxt_s;
            nbits_r    <= nbits_nxt_s;
            par_en_r   <= par_en_nxt_s;
            even_r     <= even_nxt_s;
            stop2_r    <= stop2_nxt_s;
        end
    end

    // Next-state logic; frame configuration tracks the inputs only while in START.
    always_comb begin
        state_nxt_s    = state_r;
        sc_nxt_s       = sc_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        stop_cnt_nxt_s = stop_cnt_r;
        shift_nxt_s    = shift_r;
        perr_nxt_s     = perr_r;
        ferr_nxt_s     = ferr_r;
        nbits_nxt_s    = nbits_r;
        par_en_nxt_s   = par_en_r;
        even_nxt_s     = even_r;
        stop2_nxt_s    = stop2_r;
        push_s         = 1'b0;
        if (baud_tick && (state_r != IDLE)) begin
            sc_nxt_s = (sc_r == SC_LAST) ? SC_W'(0) : sc_r + SC_W'(1);
        end else begin
            sc_nxt_s = sc_r;
        end
        case (state_r)
            IDLE: begin
                if (rx_fall_s) begin
                    state_nxt_s    = START;
                    sc_nxt_s       = SC_W'(0);
                    bit_cnt_nxt_s  = 4'd0;
                    stop_cnt_nxt_s = 1'b0;
                    shift_nxt_s    = {DATA_MAX{1'b0}};
                    perr_nxt_s     = 1'b0;
                    ferr_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                nbits_nxt_s  = nbits_in_s;
                par_en_nxt_s = parity;
                even_nxt_s   = even;
                stop2_nxt_s  = stop;
                if (baud_tick && (sc_r == SC_MID)) begin
                    if (rx_sync_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DATA;
                        sc_nxt_s    = SC_W'(0);
                    end
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (sample_s) begin
                    for (int i = 0; i < DATA_MAX; i++) begin
                        if (bit_cnt_r == 4'(i)) begin
                            shift_nxt_s[i] = rx_sync_r;
                        end else begin
                            shift_nxt_s[i] = shift_r[i];
                        end
                    end
                    if (bit_cnt_r == (nbits_r - 4'd1)) begin
                        bit_cnt_nxt_s = 4'd0;
                        state_nxt_s   = par_en_r ? PAR : STOP;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PAR: begin
                if (sample_s) begin
                    perr_nxt_s  = (rx_sync_r != expected_parity(shift_r, even_r));
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PAR;
                end
            end
            STOP: begin
                if (sample_s) begin
                    ferr_nxt_s = ferr_r | ~rx_sync_r;
                    if (stop_cnt_r == stop2_r) begin
                        push_s         = 1'b1;
                        stop_cnt_nxt_s = 1'b0;
                        state_nxt_s    = IDLE;
                    end else begin
                        stop_cnt_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        push_word_s = {shift_nxt_s, perr_nxt_s, ferr_nxt_s};
    end

    logic pop_s, full_s, wr_s, ovr_set_s, valid_nxt_s;
    logic [WORD_W-1:0] head_nxt_s;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0] wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;

    // Storage control; the output register is preloaded with whatever is head after this edge.
    always_comb begin
        pop_s      = ack & valid;
        full_s     = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        wr_s       = push_s & (~full_s | pop_s);
        ovr_set_s  = push_s & full_s & ~pop_s;
        wptr_nxt_s = wptr_r + PW'(wr_s);
        rptr_nxt_s = rptr_r + PW'(pop_s);
        if (wptr_nxt_s == rptr_nxt_s) begin
            valid_nxt_s = 1'b0;
            head_nxt_s  = {data, parity_err, frame_err};
        end else if (wr_s && (wptr_r[AW-1:0] == rptr_nxt_s[AW-1:0])) begin
            valid_nxt_s = 1'b1;
            head_nxt_s  = push_word_s;
        end else begin
            valid_nxt_s = 1'b1;
            head_nxt_s  = mem_r[rptr_nxt_s[AW-1:0]];
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= PW'(0);
            rptr_r <= PW'(0);
        end else begin
            wptr_r <= wptr_nxt_s;
            rptr_r <= rptr_nxt_s;
        end
    end

    // FIFO array write; contents are meaningless until the pointers cover them.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wptr_r[AW-1:0]] <= push_word_s;
        end
    end
`else
    logic unused_depth_s;
    assign unused_depth_s = (FIFO_DEPTH > 0);

    // Single holding register: a pop in the same clk frees the slot for an incoming word.
    always_comb begin
        pop_s     = ack & valid;
        full_s    = valid;
        wr_s      = push_s & (~full_s | pop_s);
        ovr_set_s = push_s & full_s & ~pop_s;
        if (wr_s) begin
            valid_nxt_s = 1'b1;
            head_nxt_s  = push_word_s;
        end else if (pop_s) begin
            valid_nxt_s = 1'b0;
            head_nxt_s  = {data, parity_err, frame_err};
        end else begin
            valid_nxt_s = valid;
            head_nxt_s  = {data, parity_err, frame_err};
        end
    end
`endif

    // Registered head-of-queue outputs and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= {DATA_MAX{1'b0}};
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data       <= head_nxt_s[WORD_W-1:2];
            parity_err <= head_nxt_s[1];
            frame_err  <= head_nxt_s[0];
            valid      <= valid_nxt_s;
            overrun    <= overrun | ovr_set_s;
        end
    end

endmodule
